// File: rtl/aibnd_clkrx_det.sv
// -----------------------------------------------------------------------------
// aibnd_clkrx_det
//
// Purpose:
//   Detects the forwarded clock from the link partner. Outputs the
//   polarity-restored clock. Counts rxclk rising edges over a programmable
//   window of local clk cycles, and reports whether the count falls inside
//   an inclusive pass range.
//
//   The FSM has four states:
//     IDLE    -> MEASURE  once enabled.
//     MEASURE -> LOCKED   on the first passing window.
//     LOCKED  -> LOST     on a failing window. LOST lasts one cycle and
//                         raises clk_lost.
//     LOST    -> MEASURE  unconditionally.
//
// Optional feature:
//   AIBND_CLKRX_STICKY_EN - when defined, lost_sticky is a flop. It is set
//   on every clk_lost pulse and holds until reset. When undefined,
//   lost_sticky is tied to 0.
//
// Ports:
//   clk         in   local reference clock; everything runs on its rising edge
//   reset       in   synchronous, active-high reset
//   vccl, vssl  io   supply pins, no logic function
//   rxclk       in   forwarded clock, asynchronous to clk, arrives inverted
//   cfg_en      in   detector enable
//   cfg_win     in   [7:0] window length minus 1, in clk cycles
//   cfg_min     in   [7:0] inclusive lower bound of edges per window
//   cfg_max     in   [7:0] inclusive upper bound of edges per window
//   clkout      out  !rxclk, purely combinational
//   clk_det     out  1 while in LOCKED
//   clk_lost    out  one-cycle pulse on a loss from LOCKED
//   edge_cnt    out  [7:0] edge count of the last completed window
//   lost_sticky out  sticky loss flag (see optional feature above)
// -----------------------------------------------------------------------------
module aibnd_clkrx_det (
    input  logic       clk,
    input  logic       reset,
    inout  wire        vccl,
    inout  wire        vssl,
    input  logic       rxclk,
    input  logic       cfg_en,
    input  logic [7:0] cfg_win,
    input  logic [7:0] cfg_min,
    input  logic [7:0] cfg_max,
    output logic       clkout,
    output logic       clk_det,
    output logic       clk_lost,
    output logic [7:0] edge_cnt,
    output logic       lost_sticky
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    // The supply pins carry no logic. They are folded into a sink so that
    // they are visibly consumed.
    wire w_unused_supply;
    assign w_unused_supply = vccl ^ vssl;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_sync;        // [0],[1] synchronizer; [2] edge-detect delay
    logic [7:0] r_win_cnt;
    logic [7:0] w_win_next;
    logic [7:0] r_acc;
    logic [7:0] w_acc_next;
    logic [7:0] r_edge_cnt;
    logic [7:0] w_edge_next;
    logic       w_edge;
    logic [7:0] w_acc_sum;
    logic       w_pass;
    logic       w_win_end;

    // The partner clock arrives inverted. Restoring it has no register
    // stage, so reset and enable do not affect it.
    assign clkout = ~rxclk;

    // One-cycle strobe per rxclk rise, seen after the 2-flop synchronizer.
    assign w_edge = r_sync[1] & ~r_sync[2];

    // Running total including this cycle's strobe. It clamps at 255.
    // The clamp is unreachable with legal rxclk phases but is kept for
    // robustness.
    assign w_acc_sum = (r_acc == 8'hFF) ? r_acc : (r_acc + 8'(w_edge));

    // When cfg_min > cfg_max, both bounds cannot hold, so the window never
    // passes.
    assign w_pass = (cfg_min <= w_acc_sum) && (w_acc_sum <= cfg_max);

    assign w_win_end = ((r_state == ST_MEASURE) || (r_state == ST_LOCKED))
                       && (r_win_cnt == cfg_win);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= 3'b000;
            r_state    <= ST_IDLE;
            r_win_cnt  <= 8'd0;
            r_acc      <= 8'd0;
            r_edge_cnt <= 8'd0;
        end else begin
            r_sync     <= {r_sync[1:0], rxclk};
            r_state    <= w_state_next;
            r_win_cnt  <= w_win_next;
            r_acc      <= w_acc_next;
            r_edge_cnt <= w_edge_next;
        end
    end

    // Next state and counters. The counters default to cleared, so every
    // path other than mid-window counting restarts the window from 0.
    always_comb begin
        w_state_next = r_state;
        w_win_next   = 8'd0;
        w_acc_next   = 8'd0;
        w_edge_next  = r_edge_cnt;

        if (!cfg_en) begin
            // Dropping the enable abandons the partial window. edge_cnt is
            // held, and no loss is reported.
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_MEASURE;
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (w_win_end) begin
                        w_edge_next = w_acc_sum;
                        if (w_pass) begin
                            w_state_next = ST_LOCKED;
                        end else if (r_state == ST_LOCKED) begin
                            w_state_next = ST_LOST;
                        end else begin
                            w_state_next = ST_MEASURE;
                        end
                    end else begin
                        w_win_next = r_win_cnt + 8'd1;
                        w_acc_next = w_acc_sum;
                    end
                end
                ST_LOST: begin
                    w_state_next = ST_MEASURE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign clk_det  = (r_state == ST_LOCKED);
    assign clk_lost = (r_state == ST_LOST);
    assign edge_cnt = r_edge_cnt;

`ifdef AIBND_CLKRX_STICKY_EN
    // The flag is set on the edge that enters LOST, so it rises together
    // with clk_lost. It is cleared only by reset.
    logic r_lost_sticky;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lost_sticky <= 1'b0;
        end else if (w_state_next == ST_LOST) begin
            r_lost_sticky <= 1'b1;
        end
    end

    assign lost_sticky = r_lost_sticky;
`else
    assign lost_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_aibnd_clkrx_det.sv
// -----------------------------------------------------------------------------
// tb_aibnd_clkrx_det
//
// Self-checking bench for aibnd_clkrx_det.
//
// Each scenario pushes expectations onto a queue when its stimulus is
// driven. Every expectation is stamped with the absolute clk cycle at which
// it applies. A negedge monitor pops and compares each entry when that
// cycle arrives.
//
// rxclk is generated in step with clk, with a programmable half-period, so
// the edge counts per window are exact.
// -----------------------------------------------------------------------------
module tb_aibnd_clkrx_det;

`ifdef AIBND_CLKRX_STICKY_EN
    localparam int STICKY = 1;
`else
    localparam int STICKY = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxclk = 1'b0;
    logic       cfg_en = 1'b0;
    logic [7:0] cfg_win = 8'd0;
    logic [7:0] cfg_min = 8'd0;
    logic [7:0] cfg_max = 8'd0;
    wire        vccl;
    wire        vssl;
    logic       clkout;
    logic       clk_det;
    logic       clk_lost;
    logic [7:0] edge_cnt;
    logic       lost_sticky;

    assign vccl = 1'b1;
    assign vssl = 1'b0;

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lost_cnt = 0;
    int base     = 0;
    int rx_half  = 5;
    int rx_ph    = 0;
    bit rx_run   = 1'b0;

    typedef struct {
        int    at;
        string tag;
        int    sel;   // 0 edge_cnt, 1 clk_det, 2 clk_lost, 3 lost_sticky, 4 edge_cnt<=1
        int    val;
    } exp_t;

    exp_t sb_q[$];

    aibnd_clkrx_det dut (
        .clk         (clk),
        .reset       (reset),
        .vccl        (vccl),
        .vssl        (vssl),
        .rxclk       (rxclk),
        .cfg_en      (cfg_en),
        .cfg_win     (cfg_win),
        .cfg_min     (cfg_min),
        .cfg_max     (cfg_max),
        .clkout      (clkout),
        .clk_det     (clk_det),
        .clk_lost    (clk_lost),
        .edge_cnt    (edge_cnt),
        .lost_sticky (lost_sticky)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic int observe(input int sel);
        case (sel)
            0:       return int'(edge_cnt);
            1:       return int'(clk_det);
            2:       return int'(clk_lost);
            3:       return int'(lost_sticky);
            4:       return (edge_cnt <= 8'd1) ? 1 : 0;
            default: return -1;
        endcase
    endfunction

    task automatic sb_push(input int at, input string tag, input int sel, input int val);
        exp_t e;
        e.at  = at;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // rxclk generator: it toggles on negedges, so period = 2*rx_half clk cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!rx_run) begin
                rxclk = 1'b0;
                rx_ph = 0;
            end else begin
                rx_ph = rx_ph + 1;
                if (rx_ph >= rx_half) begin
                    rxclk = ~rxclk;
                    rx_ph = 0;
                end
            end
        end
    end

    // Monitor: counts loss pulses and compares the expectations due this cycle.
    always @(negedge clk) begin
        if (clk_lost === 1'b1) lost_cnt++;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].at == cyc) begin
                chk(sb_q[i].tag, observe(sb_q[i].sel), sb_q[i].val);
                $display("[TB] cycle %0d check %s", cyc, sb_q[i].tag);
                sb_q.delete(i);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sum;

        // Reset state.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_edge_cnt", int'(edge_cnt), 0);
        chk("rst_clk_det", int'(clk_det), 0);
        chk("rst_clk_lost", int'(clk_lost), 0);
        chk("rst_sticky", int'(lost_sticky), 0);
        reset = 1'b0;

        // Lock: period 10, 100-cycle window, pass range 9..11.
        cfg_win = 8'd99;
        cfg_min = 8'd9;
        cfg_max = 8'd11;
        rx_half = 5;
        rx_run  = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            chk("clkout", int'(clkout), int'(!rxclk));
        end
        @(negedge clk);
        repeat (12) @(negedge clk);
        base = cyc;
        cfg_en = 1'b1;
        sb_push(base + 100, "lock_det_early", 1, 0);
        sb_push(base + 101, "lock_det", 1, 1);
        sb_push(base + 101, "lock_cnt", 0, 10);
        sb_push(base + 101, "lock_nolost", 2, 0);

        // Loss: stop rxclk right after lock; the next window fails.
        wait_cyc(base + 101);
        rx_run = 1'b0;
        sb_push(base + 200, "loss_det_before", 1, 1);
        sb_push(base + 201, "loss_pulse", 2, 1);
        sb_push(base + 201, "loss_det", 1, 0);
        sb_push(base + 201, "loss_cnt_le1", 4, 1);
        sb_push(base + 201, "loss_sticky", 3, STICKY);
        sb_push(base + 202, "loss_pulse_end", 2, 0);
        sb_push(base + 202, "loss_det_after", 1, 0);
        sb_push(base + 202, "loss_sticky_hold", 3, STICKY);
        wait_cyc(base + 205);
        cfg_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("lost_count_loss", lost_cnt, 1);

        // Out of range: period 4 gives 25 edges per window.
        rx_half = 2;
        rx_run  = 1'b1;
        repeat (20) @(negedge clk);
        base = cyc;
        cfg_en = 1'b1;
        sb_push(base + 101, "oor_cnt1", 0, 25);
        sb_push(base + 101, "oor_det1", 1, 0);
        sb_push(base + 201, "oor_cnt2", 0, 25);
        sb_push(base + 201, "oor_det2", 1, 0);
        wait_cyc(base + 205);
        chk("lost_count_oor", lost_cnt, 1);
        cfg_en = 1'b0;
        repeat (3) @(negedge clk);

        // Single-cycle windows; inverted range so it never locks.
        cfg_win = 8'd0;
        cfg_min = 8'd12;
        cfg_max = 8'd8;
        base = cyc;
        cfg_en = 1'b1;
        for (int k = 2; k <= 9; k++) sb_push(base + k, "win0_le1", 4, 1);
        wait_cyc(base + 2);
        sum = 0;
        repeat (8) begin
            sum += int'(edge_cnt);
            @(negedge clk);
        end
        chk("win0_sum", sum, 2);
        chk("win0_det", int'(clk_det), 0);
        cfg_en = 1'b0;
        repeat (3) @(negedge clk);

        // Longest window: 256 cycles at period 4 gives 64 edges, no clamp.
        cfg_win = 8'd255;
        cfg_min = 8'd60;
        cfg_max = 8'd255;
        base = cyc;
        cfg_en = 1'b1;
        sb_push(base + 256, "maxwin_det_early", 1, 0);
        sb_push(base + 257, "maxwin_cnt", 0, 64);
        sb_push(base + 257, "maxwin_det", 1, 1);
        wait_cyc(base + 260);
        cfg_en = 1'b0;
        repeat (3) @(negedge clk);

        // Inverted range with an in-band count: still never locks.
        cfg_win = 8'd99;
        cfg_min = 8'd12;
        cfg_max = 8'd8;
        rx_half = 5;
        repeat (20) @(negedge clk);
        base = cyc;
        cfg_en = 1'b1;
        sb_push(base + 101, "inv_cnt1", 0, 10);
        sb_push(base + 101, "inv_det1", 1, 0);
        sb_push(base + 201, "inv_cnt2", 0, 10);
        sb_push(base + 201, "inv_det2", 1, 0);
        wait_cyc(base + 205);
        cfg_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("lost_count_inv", lost_cnt, 1);

        // Disable while LOCKED: IDLE, no clk_lost, edge_cnt held.
        cfg_min = 8'd9;
        cfg_max = 8'd11;
        base = cyc;
        cfg_en = 1'b1;
        sb_push(base + 101, "dis_locked", 1, 1);
        wait_cyc(base + 150);
        cfg_en = 1'b0;
        sb_push(base + 151, "dis_det", 1, 0);
        sb_push(base + 151, "dis_lost", 2, 0);
        sb_push(base + 151, "dis_cnt_hold", 0, 10);
        sb_push(base + 160, "dis_cnt_hold2", 0, 10);
        sb_push(base + 160, "dis_det2", 1, 0);
        wait_cyc(base + 165);
        chk("lost_count_dis", lost_cnt, 1);

        // Reset mid-window while LOCKED.
        base = cyc;
        cfg_en = 1'b1;
        sb_push(base + 101, "rst_locked", 1, 1);
        wait_cyc(base + 150);
        reset = 1'b1;
        sb_push(base + 151, "rstmid_cnt", 0, 0);
        sb_push(base + 151, "rstmid_det", 1, 0);
        sb_push(base + 151, "rstmid_lost", 2, 0);
        sb_push(base + 151, "rstmid_sticky", 3, 0);
        wait_cyc(base + 151);
        #1;
        chk("rstmid_clkout", int'(clkout), int'(!rxclk));
        reset = 1'b0;
        sb_push(base + 160, "rstmid_det_after", 1, 0);
        wait_cyc(base + 165);
        chk("lost_count_rst", lost_cnt, 1);
        cfg_en = 1'b0;
        repeat (2) @(negedge clk);

        chk("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aibnd_clkrx_det.md
AIBND_CLKRX_DET -- requirements
Module: aibnd_clkrx_det

Interface
REQ-001 Single clock domain on clk; reset is synchronous and active-high on reset.
REQ-002 clk  input  1  local reference clock; all sequential logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 vccl, vssl  inout  1 each  supply pins; no logic function.
REQ-005 rxclk  input  1  forwarded clock from the link partner, asynchronous to clk, arriving inverted.
REQ-006 cfg_en  input  1  detector enable.
REQ-007 cfg_win  input  8  measurement window length minus 1, in clk cycles.
REQ-008 cfg_min, cfg_max  input  8 each  inclusive pass range for rxclk rising edges per window.
REQ-009 clkout  output  1  polarity-restored forwarded clock, combinational !rxclk.
REQ-010 clk_det  output  1  forwarded clock present and in range.
REQ-011 clk_lost  output  1  one-cycle pulse on loss from LOCKED.
REQ-012 edge_cnt  output  8  rxclk rising-edge count of the last completed window.
REQ-013 lost_sticky  output  1  sticky loss flag; see Configuration.

Function
REQ-014 clkout SHALL equal !rxclk with no register stage; it is unaffected by reset and cfg_en.
REQ-015 rxclk SHALL pass through a 2-flop synchronizer and a third flop; the edge strobe is sync2 & !sync3.
REQ-016 Latency from an rxclk rise to the edge strobe SHALL be at most 3 clk cycles; rxclk high and low phases are each at least 2 clk cycles.
REQ-017 FSM states SHALL be IDLE, MEASURE, LOCKED, and LOST.
REQ-018 IDLE SHALL move to MEASURE on the cycle after cfg_en=1, with the window counter and accumulator cleared.
REQ-019 In MEASURE and LOCKED, the window counter SHALL increment every cycle, and the accumulator SHALL increment on each edge strobe, saturating at 255.
REQ-020 The window SHALL end on the cycle the window counter equals cfg_win, giving cfg_win+1 cycles; cfg_win=0 gives a 1-cycle window.
REQ-021 At window end, edge_cnt SHALL load the accumulator including any strobe in that cycle, and both counters SHALL restart from 0 next cycle.
REQ-022 A window SHALL pass when cfg_min <= edge_cnt <= cfg_max; cfg_min > cfg_max never passes.
REQ-023 In MEASURE, a pass SHALL move to LOCKED and a fail SHALL stay in MEASURE.
REQ-024 clk_det SHALL be 1 exactly while in LOCKED, asserted the cycle after the passing window end.
REQ-025 In LOCKED, a fail SHALL move to LOST, with clk_lost=1 and clk_det=0 for that one cycle.
REQ-026 LOST SHALL move to MEASURE unconditionally after 1 cycle.
REQ-027 cfg_en=0 in any state SHALL move to IDLE next cycle, clear clk_det, hold edge_cnt, and generate no clk_lost.
REQ-028 cfg changes mid-window SHALL take effect at the next comparison; no window restart.

Reset
REQ-029 reset=1 SHALL force IDLE and clear all synchronizer flops, counters, the accumulator, edge_cnt, clk_det, clk_lost and lost_sticky on the next clk edge.
REQ-030 reset asserted mid-window SHALL discard the partial window and generate no clk_lost pulse.

Configuration
REQ-031 With macro AIBND_CLKRX_STICKY_EN defined, lost_sticky SHALL set on any clk_lost pulse and hold until reset, independent of cfg_en.
REQ-032 Without AIBND_CLKRX_STICKY_EN, lost_sticky SHALL be tied to 0 with no flop, and all other behaviour is identical.

Verification
REQ-033 Lock: cfg_win=99, cfg_min=9, cfg_max=11, rxclk period 10 clk, cfg_en=1 -> edge_cnt=10 and clk_det=1 the cycle after the first window end.
REQ-034 Loss: from LOCKED, stop rxclk -> next window end gives edge_cnt 0 or 1, a 1-cycle clk_lost, clk_det=0, then LOST->MEASURE; lost_sticky=1 only with the macro.
REQ-035 Out of range: rxclk period 4 clk with the same cfg -> edge_cnt=25, clk_det stays 0, no clk_lost.
REQ-036 Boundaries: cfg_win=0 -> edge_cnt is 0 or 1 every cycle; rxclk period 4 with cfg_win=255 and cfg_max=255 -> no saturation, edge_cnt=64; cfg_min=12, cfg_max=8 -> never locks.
REQ-037 Disable and reset: cfg_en=0 while LOCKED -> IDLE, clk_det=0, no clk_lost; reset mid-window -> all outputs 0 next cycle except clkout=!rxclk.
